// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the alignment rule applied at request acceptance.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Illegal size or a halfword/word not naturally aligned is rejected up front.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Right-justified load data extension: byte/halfword zero- or sign-extended,
// words passed through.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      SIZE_HALF: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:   data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and a RAM responder: latches a
// request, holds mem_enable for WAIT_CYCLES cycles, then pulses a response.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_ACCESS | mem_enable held, wait counter running down
// ST_DONE   | one-cycle response pulse
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              enable_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       ext_data;

  load_extend u_load_extend (
    .size_i   (size_q),
    .signed_i (signed_q),
    .raw_i    (mem_rdata),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            ready_q  <= 1'b0;
            if (is_bad_access(req_size, req_addr[1:0])) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q  <= ST_ACCESS;
              enable_q <= 1'b1;
              cnt_q    <= CNT_INIT;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_DONE;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= write_q ? 32'd0 : ext_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_fault  = rsp_fault_q;
  assign mem_enable = enable_q;
  // Gating with enable keeps mem_rw low outside ACCESS without extra state.
  assign mem_rw     = enable_q & write_q;
  assign mem_addr   = addr_q;
  assign mem_size   = size_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: two units (WAIT_CYCLES 1 and 3), each with a big-endian
// byte RAM responder; expected responses are queued at handshake time.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [7:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_fault  [2];
  logic        mem_enable [2];
  logic        mem_rw     [2];
  logic [7:0]  mem_addr   [2];
  logic [1:0]  mem_size   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  logic [7:0] ram [2][256];

  mem_access_unit #(.WAIT_CYCLES(1), .ADDR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0]), .mem_enable(mem_enable[0]),
    .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]), .mem_size(mem_size[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_access_unit #(.WAIT_CYCLES(3), .ADDR_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1]), .mem_enable(mem_enable[1]),
    .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]), .mem_size(mem_size[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Big-endian responder: lowest address holds the most significant byte.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_enable[i] && mem_rw[i]) begin
        case (mem_size[i])
          2'b00: ram[i][mem_addr[i]] <= mem_wdata[i][7:0];
          2'b01: begin
            ram[i][mem_addr[i]]         <= mem_wdata[i][15:8];
            ram[i][mem_addr[i] + 8'd1]  <= mem_wdata[i][7:0];
          end
          default: begin
            ram[i][mem_addr[i]]         <= mem_wdata[i][31:24];
            ram[i][mem_addr[i] + 8'd1]  <= mem_wdata[i][23:16];
            ram[i][mem_addr[i] + 8'd2]  <= mem_wdata[i][15:8];
            ram[i][mem_addr[i] + 8'd3]  <= mem_wdata[i][7:0];
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 32'hA5A5_5A5A;
      if (mem_enable[i] && !mem_rw[i]) begin
        case (mem_size[i])
          2'b00:   mem_rdata[i] = {24'h0, ram[i][mem_addr[i]]};
          2'b01:   mem_rdata[i] = {16'h0, ram[i][mem_addr[i]], ram[i][mem_addr[i] + 8'd1]};
          default: mem_rdata[i] = {ram[i][mem_addr[i]], ram[i][mem_addr[i] + 8'd1],
                                   ram[i][mem_addr[i] + 8'd2], ram[i][mem_addr[i] + 8'd3]};
        endcase
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
    logic        write;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          en;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   en_cnt [2];
  int   checks   = 0;
  int   failures = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   qs;
    chk($sformatf("rw_without_enable[%0d]", i), {31'd0, mem_rw[i] & ~mem_enable[i]}, 32'd0);
    qs = (i == 0) ? q0.size() : q1.size();
    if (!rst_n[i]) en_cnt[i] = 0;
    else if (mem_enable[i]) begin
      en_cnt[i]++;
      if (qs > 0) begin
        e = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("mem_addr[%0d]", i),  {24'd0, mem_addr[i]}, {24'd0, e.addr});
        chk($sformatf("mem_rw[%0d]", i),    {31'd0, mem_rw[i]},   {31'd0, e.write});
        chk($sformatf("mem_size[%0d]", i),  {30'd0, mem_size[i]}, {30'd0, e.size});
        chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], e.wdata);
      end
    end
    if (rsp_valid[i]) begin
      if (qs == 0) begin
        chk($sformatf("unexpected_rsp[%0d]", i), 32'd1, 32'd0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp_cycle[%0d]", i), cyc, e.cyc);
        chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], e.rdata);
        chk($sformatf("rsp_fault[%0d]", i), {31'd0, rsp_fault[i]}, {31'd0, e.fault});
        chk($sformatf("enable_cycles[%0d]", i), en_cnt[i], e.en);
      end
      en_cnt[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int i, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [7:0] ad, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input logic push,
                       output int n);
    exp_t e;
    int   t;
    @(negedge clk);
    req_write[i]  = wr;
    req_size[i]   = sz;
    req_signed[i] = sg;
    req_addr[i]   = ad;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    t = 0;
    while (!req_ready[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[i]) begin
      chk($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      n = -1;
      return;
    end
    @(posedge clk);
    #1;
    n = cyc;
    req_valid[i] = 1'b0;
    if (push) begin
      e.cyc   = exp_f ? n : n + lat(i);
      e.rdata = exp_rd;
      e.fault = exp_f;
      e.write = wr;
      e.size  = sz;
      e.addr  = ad;
      e.wdata = wd;
      e.en    = exp_f ? 0 : lat(i);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic chk_reset_state(input int i, input string tag);
    chk($sformatf("%s_ready[%0d]", tag, i),  {31'd0, req_ready[i]},  32'd1);
    chk($sformatf("%s_valid[%0d]", tag, i),  {31'd0, rsp_valid[i]},  32'd0);
    chk($sformatf("%s_rdata[%0d]", tag, i),  rsp_rdata[i],           32'd0);
    chk($sformatf("%s_fault[%0d]", tag, i),  {31'd0, rsp_fault[i]},  32'd0);
    chk($sformatf("%s_enable[%0d]", tag, i), {31'd0, mem_enable[i]}, 32'd0);
    chk($sformatf("%s_rw[%0d]", tag, i),     {31'd0, mem_rw[i]},     32'd0);
    chk($sformatf("%s_addr[%0d]", tag, i),   {24'd0, mem_addr[i]},   32'd0);
    chk($sformatf("%s_size[%0d]", tag, i),   {30'd0, mem_size[i]},   32'd0);
    chk($sformatf("%s_wdata[%0d]", tag, i),  mem_wdata[i],           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n1, n2, t;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
      req_signed[i] = 1'b0; req_addr[i] = 8'h00; req_wdata[i] = 32'h0; en_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset_state(0, "reset");
    chk_reset_state(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // WAIT_CYCLES = 1
    issue(0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, n1);
    issue(0, 1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b1, n2);
    chk("accept_spacing_w1", n2 - n1, 32'd3);
    issue(0, 1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 32'h0000BEEF, 1'b0, 1'b1, n1);
    issue(0, 1'b0, 2'b10, 1'b0, 8'h11, 32'h0, 32'h0, 1'b1, 1'b1, n1);
    issue(0, 1'b0, 2'b11, 1'b0, 8'h20, 32'h0, 32'h0, 1'b1, 1'b1, n2);
    chk("accept_spacing_fault", n2 - n1, 32'd2);
    issue(0, 1'b0, 2'b01, 1'b1, 8'h13, 32'h0, 32'h0, 1'b1, 1'b1, n1);
    issue(0, 1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 32'h000000AD, 1'b0, 1'b1, n1);
    issue(0, 1'b0, 2'b01, 1'b1, 8'h10, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b1, n1);
    issue(0, 1'b1, 2'b01, 1'b1, 8'h12, 32'h00001111, 32'h0, 1'b0, 1'b1, n1);
    issue(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEAD1111, 1'b0, 1'b1, n1);
    issue(0, 1'b1, 2'b10, 1'b0, 8'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, n1);
    issue(0, 1'b0, 2'b10, 1'b1, 8'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, n1);

    // WAIT_CYCLES = 3
    issue(1, 1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678, 32'h0, 1'b0, 1'b1, n1);
    issue(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h12345678, 1'b0, 1'b1, n1);
    issue(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h12345678, 1'b0, 1'b1, n2);
    chk("accept_spacing_w3", n2 - n1, 32'd5);
    issue(1, 1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 32'h00000078, 1'b0, 1'b1, n1);
    issue(1, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 32'h00005678, 1'b0, 1'b1, n1);

    // Reset in the second of three ACCESS cycles discards the request.
    issue(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 1'b0, n1);
    @(posedge clk);
    #2;
    chk("pre_reset_enable", {31'd0, mem_enable[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_state(1, "midreset");
    repeat (4) @(negedge clk);
    rst_n[1] = 1'b1;
    issue(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h12345678, 1'b0, 1'b1, n1);

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q0.size() + q1.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: number of cycles mem_enable is held per access; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 8: memory byte-address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  pipeline access request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_write  input  1  request type: 0 load, 1 store.
REQ-009 req_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_signed  input  1  sign-extend load result; ignored for words and stores.
REQ-011 req_addr  input  ADDR_W  byte address; big-endian.
REQ-012 req_wdata  input  32  store data, right-justified.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-015 rsp_fault  output  1  qualifies rsp_valid: access rejected.
REQ-016 mem_enable, mem_rw, mem_addr[ADDR_W], mem_size[2], mem_wdata[32]  outputs  drive the RAM responder's Enable, ReadWrite, Address, Size and DataIn.
REQ-017 mem_rdata  input  32  RAM responder DataOut.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-019 IDLE: req_ready=1; a handshake (req_valid&req_ready) latches every req_* field.
REQ-020 On handshake, size 11, halfword with addr[0]=1, or word with addr[1:0]!=00 SHALL go to DONE with fault set and SHALL NOT assert mem_enable.
REQ-021 Otherwise SHALL go to ACCESS and load wait counter with WAIT_CYCLES-1.
REQ-022 ACCESS: mem_enable=1 and mem_rw/addr/size/wdata driven from registered request, stable for the whole state; req_ready=0.
REQ-023 ACCESS: counter decrements each cycle; at 0 a load captures mem_rdata and state goes to DONE.
REQ-024 Load extension: byte -> mem_rdata[7:0] zero- or sign-extended from bit 7; halfword -> [15:0] extended from bit 15; word unchanged.
REQ-025 DONE: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE; no response back-pressure exists.
REQ-026 Latency: handshake on edge N -> rsp_valid high in cycle N+1+WAIT_CYCLES (N+1 for faults); sustained throughput one access per WAIT_CYCLES+2 cycles.
REQ-027 mem_enable SHALL be 0 in IDLE and DONE; mem_rw SHALL be 0 whenever mem_enable=0.
REQ-028 mem_wdata SHALL equal req_wdata unmodified; byte/halfword lane selection belongs to the responder.
REQ-029 Stores SHALL complete with rsp_rdata=0, rsp_fault=0.
REQ-030 Last aligned word (address 2^ADDR_W-4) SHALL be legal; no address wrap is generated.

Reset
REQ-031 Reset SHALL force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_enable=0, mem_rw=0, mem_addr=0, mem_size=0, mem_wdata=0.
REQ-032 Reset mid-ACCESS SHALL drop mem_enable asynchronously and discard the request with no response.

Structure
REQ-033 Shared package mem_pkg SHALL hold size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum.
REQ-034 Extension logic SHALL be sub-module load_extend (size, signed, raw data -> 32-bit result).

Verification
REQ-035 Store word 0xDEADBEEF @0x10 -> single ACCESS with mem_rw=1, mem_size=10, rsp_valid at N+2, rsp_fault=0.
REQ-036 Then signed byte load @0x10 -> rsp_rdata=0xFFFFFFDE; unsigned halfword @0x12 -> 0x0000BEEF.
REQ-037 Word load @0x11 and size 11 @0x20 -> rsp_fault=1 at N+1, mem_enable never high.
REQ-038 WAIT_CYCLES=3, back-to-back word loads @0x10 -> mem_enable high 3 cycles each, rsp_valid at N+4, next accept at N+5.
REQ-039 rst_n low during ACCESS cycle 2 of 3 -> mem_enable 0 immediately, no rsp_valid, next request served normally.
